// File: rtl/cpu_axi_pkg.sv
// Shared types and AXI3 constants for the CPU SRAM-to-AXI bridge.
package cpu_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;

    localparam logic [LEN_W-1:0] AXI_LEN        = LEN_W'(0);
    localparam logic [2:0]       AXI_SIZE       = 3'd2;
    localparam logic [1:0]       AXI_BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_D_AR,
        ST_D_R,
        ST_D_AW,
        ST_D_B,
        ST_I_AR,
        ST_I_R,
        ST_DONE
    } state_e;

    // Latched store payload, held stable while awvalid/wvalid are pending.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strb;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // kseg0 (100) and kseg1 (101) both alias physical address space at 000.
    function automatic logic [ADDR_W-1:0] kseg_map(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] pa;
        pa = addr;
        if (addr[31:30] == 2'b10) begin
            pa[31:29] = 3'b000;
        end
        return pa;
    endfunction

endpackage

// File: rtl/cpu_sram_axi_bridge_if.sv
// Core-side SRAM request bundle and single-beat AXI3 master bundle.
interface cpu_sram_if;
    import cpu_axi_pkg::*;

    logic              inst_en;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_en;
    logic [STRB_W-1:0] data_wen;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              stall;

    modport master (
        output inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        input  inst_rdata, data_rdata, stall
    );

    modport slave (
        input  inst_en, inst_addr, data_en, data_wen, data_addr, data_wdata,
        output inst_rdata, data_rdata, stall
    );
endinterface

interface axi3_if;
    import cpu_axi_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;
    logic              rready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   wid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
               awid, awaddr, awlen, awsize, awburst, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rvalid, awready, wready, bvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
               awid, awaddr, awlen, awsize, awburst, awvalid,
               wid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rvalid, awready, wready, bvalid
    );
endinterface

// File: rtl/cpu_sram_axi_bridge.sv
// Serves the core's inst/data SRAM ports over one AXI3 master, one single-beat
// transaction at a time; data is served before inst when both request together.
module cpu_sram_axi_bridge
    import cpu_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] AXI_ID   = 4'd0,
    parameter bit              MAP_KSEG = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    cpu_sram_if.slave  core_io,
    axi3_if.master     axi_io
);

    state_e            state_q;
    logic              inst_pend_q;
    logic [ADDR_W-1:0] inst_addr_q;
    logic              arvalid_q;
    logic [ADDR_W-1:0] araddr_q;
    logic              rready_q;
    logic              awvalid_q;
    logic              wvalid_q;
    wr_req_t           wr_q;
    logic              bready_q;
    logic [DATA_W-1:0] inst_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;

    logic req_c;
    logic aw_done_c;
    logic w_done_c;

    function automatic logic [ADDR_W-1:0] phys_addr(input logic [ADDR_W-1:0] va);
        return MAP_KSEG ? kseg_map(va) : va;
    endfunction

    assign req_c     = core_io.data_en | core_io.inst_en;
    assign aw_done_c = !awvalid_q || axi_io.awready;
    assign w_done_c  = !wvalid_q  || axi_io.wready;

    // Stall rises combinationally on a new request so the core holds it in the accept cycle.
    assign core_io.stall = !reset && (state_q != ST_DONE) && !((state_q == ST_IDLE) && !req_c);

    assign core_io.inst_rdata = inst_rdata_q;
    assign core_io.data_rdata = data_rdata_q;

    assign axi_io.arid    = AXI_ID;
    assign axi_io.araddr  = araddr_q;
    assign axi_io.arlen   = AXI_LEN;
    assign axi_io.arsize  = AXI_SIZE;
    assign axi_io.arburst = AXI_BURST_INCR;
    assign axi_io.arvalid = arvalid_q;
    assign axi_io.rready  = rready_q;

    assign axi_io.awid    = AXI_ID;
    assign axi_io.awaddr  = wr_q.addr;
    assign axi_io.awlen   = AXI_LEN;
    assign axi_io.awsize  = AXI_SIZE;
    assign axi_io.awburst = AXI_BURST_INCR;
    assign axi_io.awvalid = awvalid_q;

    assign axi_io.wid     = AXI_ID;
    assign axi_io.wdata   = wr_q.data;
    assign axi_io.wstrb   = wr_q.strb;
    assign axi_io.wlast   = 1'b1;
    assign axi_io.wvalid  = wvalid_q;
    assign axi_io.bready  = bready_q;

    // Transaction sequencer; every AXI output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            inst_pend_q  <= 1'b0;
            inst_addr_q  <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            wr_q         <= '0;
            bready_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_c) begin
                        inst_pend_q <= core_io.inst_en;
                        inst_addr_q <= phys_addr(core_io.inst_addr);
                        if (core_io.data_en && (core_io.data_wen != '0)) begin
                            wr_q.addr <= phys_addr(core_io.data_addr);
                            wr_q.strb <= core_io.data_wen;
                            wr_q.data <= core_io.data_wdata;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= ST_D_AW;
                        end else if (core_io.data_en) begin
                            araddr_q  <= phys_addr(core_io.data_addr);
                            arvalid_q <= 1'b1;
                            state_q   <= ST_D_AR;
                        end else begin
                            araddr_q  <= phys_addr(core_io.inst_addr);
                            arvalid_q <= 1'b1;
                            state_q   <= ST_I_AR;
                        end
                    end
                end

                ST_D_AR, ST_I_AR: begin
                    if (axi_io.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == ST_D_AR) ? ST_D_R : ST_I_R;
                    end
                end

                ST_D_R: begin
                    if (axi_io.rvalid) begin
                        data_rdata_q <= axi_io.rdata;
                        rready_q     <= 1'b0;
                        if (inst_pend_q) begin
                            araddr_q  <= inst_addr_q;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_I_AR;
                        end else begin
                            state_q   <= ST_DONE;
                        end
                    end
                end

                ST_I_R: begin
                    if (axi_io.rvalid) begin
                        inst_rdata_q <= axi_io.rdata;
                        rready_q     <= 1'b0;
                        state_q      <= ST_DONE;
                    end
                end

                // AW and W retire independently; leave once both have handshaken.
                ST_D_AW: begin
                    if (axi_io.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (axi_io.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_done_c && w_done_c) begin
                        bready_q <= 1'b1;
                        state_q  <= ST_D_B;
                    end
                end

                ST_D_B: begin
                    if (axi_io.bvalid) begin
                        bready_q <= 1'b0;
                        if (inst_pend_q) begin
                            araddr_q  <= inst_addr_q;
                            arvalid_q <= 1'b1;
                            state_q   <= ST_I_AR;
                        end else begin
                            state_q   <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_sram_axi_bridge.sv
// Scoreboard bench for cpu_sram_axi_bridge: directed core requests, a
// configurable-latency AXI slave model and a negedge monitor.
module tb_cpu_sram_axi_bridge;
    import cpu_axi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_sram_if core_bus ();
    axi3_if     axi_bus ();

    cpu_sram_axi_bridge #(
        .AXI_ID   (4'd0),
        .MAP_KSEG (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .core_io (core_bus),
        .axi_io  (axi_bus)
    );

    typedef enum int {EV_AR, EV_AW, EV_W, EV_DONE} ev_e;
    typedef struct {
        ev_e         kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        int unsigned stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] mem [logic [31:0]];
    int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0;

    // Handshakes seen at negedge; they complete on the following posedge.
    logic        ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] ar_hs_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    endtask

    function automatic void push(input ev_e k, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] s, input int unsigned st);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.s = s; e.stalls = st;
        exp_q.push_back(e);
    endfunction

    task automatic pop_expect(input ev_e k, output exp_t e, output bit ok);
        n_checks++;
        ok = 1'b0;
        e  = '{kind: EV_AR, a: '0, b: '0, s: '0, stalls: 0};
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: unexpected %s event, nothing expected at %0t", k.name(), $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == k) begin
                n_pass++;
                ok = 1'b1;
            end else begin
                $display("FAIL scoreboard: got %s event want %s at %0t", k.name(), e.kind.name(), $time);
            end
        end
    endtask

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Monitor: pops the scoreboard on every DUT-presented event.
    int unsigned stall_cnt;
    logic        prev_arpend;
    logic [31:0] prev_araddr;
    always @(negedge clk) begin
        exp_t e;
        bit   ok;
        ar_hs      = axi_bus.arvalid && axi_bus.arready;
        r_hs       = axi_bus.rvalid  && axi_bus.rready;
        aw_hs      = axi_bus.awvalid && axi_bus.awready;
        w_hs       = axi_bus.wvalid  && axi_bus.wready;
        b_hs       = axi_bus.bvalid  && axi_bus.bready;
        ar_hs_addr = axi_bus.araddr;
        if (reset) begin
            stall_cnt   = 0;
            prev_arpend = 1'b0;
        end else begin
            if (prev_arpend) begin
                check("ar_hold_valid", 32'(axi_bus.arvalid), 32'd1);
                check("ar_hold_addr", axi_bus.araddr, prev_araddr);
            end
            prev_arpend = axi_bus.arvalid && !axi_bus.arready;
            prev_araddr = axi_bus.araddr;
            if (core_bus.stall) stall_cnt++;
            if (ar_hs) begin
                pop_expect(EV_AR, e, ok);
                if (ok) begin
                    check("araddr", axi_bus.araddr, e.a);
                    check("ar_attr", 32'({axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst}),
                          32'({4'd0, 4'd0, 3'd2, 2'b01}));
                end
            end
            if (aw_hs) begin
                pop_expect(EV_AW, e, ok);
                if (ok) begin
                    check("awaddr", axi_bus.awaddr, e.a);
                    check("aw_attr", 32'({axi_bus.awlen, axi_bus.awsize}), 32'({4'd0, 3'd2}));
                end
            end
            if (w_hs) begin
                pop_expect(EV_W, e, ok);
                if (ok) begin
                    check("wdata", axi_bus.wdata, e.b);
                    check("wstrb_wlast", 32'({axi_bus.wstrb, axi_bus.wlast}), 32'({e.s, 1'b1}));
                end
            end
            if (!core_bus.stall && (core_bus.inst_en || core_bus.data_en)) begin
                pop_expect(EV_DONE, e, ok);
                if (ok) begin
                    check("inst_rdata", core_bus.inst_rdata, e.a);
                    check("data_rdata", core_bus.data_rdata, e.b);
                    check("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
                end
                stall_cnt = 0;
            end
        end
    end

    // AXI slave model with per-channel ready/valid latency knobs.
    int ar_cnt, r_cnt, aw_cnt, w_cnt;
    bit r_pend, got_aw, got_w;
    logic [31:0] r_addr;
    always @(posedge clk) begin
        #1;
        if (reset) begin
            axi_bus.arready = 1'b0; axi_bus.rvalid = 1'b0; axi_bus.rdata = '0;
            axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0;
            r_pend = 1'b0; got_aw = 1'b0; got_w = 1'b0; r_addr = '0;
        end else begin
            if (ar_hs) begin
                axi_bus.arready = 1'b0; ar_cnt = 0;
                r_pend = 1'b1; r_cnt = 0; r_addr = ar_hs_addr;
            end else if (axi_bus.arvalid && !axi_bus.arready) begin
                if (ar_cnt >= ar_wait) axi_bus.arready = 1'b1;
                else ar_cnt++;
            end
            if (r_hs) axi_bus.rvalid = 1'b0;
            if (r_pend && !axi_bus.rvalid) begin
                if (r_cnt >= r_wait) begin
                    axi_bus.rvalid = 1'b1;
                    axi_bus.rdata  = rd_model(r_addr);
                    r_pend = 1'b0;
                end else r_cnt++;
            end
            if (aw_hs) begin
                axi_bus.awready = 1'b0; aw_cnt = 0; got_aw = 1'b1;
            end else if (axi_bus.awvalid && !axi_bus.awready) begin
                if (aw_cnt >= aw_wait) axi_bus.awready = 1'b1;
                else aw_cnt++;
            end
            if (w_hs) begin
                axi_bus.wready = 1'b0; w_cnt = 0; got_w = 1'b1;
            end else if (axi_bus.wvalid && !axi_bus.wready) begin
                if (w_cnt >= w_wait) axi_bus.wready = 1'b1;
                else w_cnt++;
            end
            if (b_hs) begin
                axi_bus.bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
            end else if (got_aw && got_w && !axi_bus.bvalid) begin
                axi_bus.bvalid = 1'b1;
            end
        end
    end

    task automatic issue(input logic ie, input logic [31:0] ia, input logic de,
                         input logic [3:0] wen, input logic [31:0] da, input logic [31:0] wd);
        core_bus.inst_en    = ie;
        core_bus.inst_addr  = ia;
        core_bus.data_en    = de;
        core_bus.data_wen   = wen;
        core_bus.data_addr  = da;
        core_bus.data_wdata = wd;
    endtask

    task automatic idle_core();
        issue(1'b0, '0, 1'b0, 4'b0000, '0, '0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (core_bus.stall && n < 200);
        if (core_bus.stall) begin
            n_checks++;
            $display("FAIL %s: stall still 1 after %0d cycles, want 0", name, n);
        end
        @(posedge clk); #1;
        idle_core();
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"},   32'(core_bus.stall), 32'd0);
        check({tag, "_valids"},  32'({axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid}), 32'd0);
        check({tag, "_readies"}, 32'({axi_bus.rready, axi_bus.bready}), 32'd0);
        check({tag, "_inst_rd"}, core_bus.inst_rdata, 32'd0);
        check({tag, "_data_rd"}, core_bus.data_rdata, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        reset = 1'b1;
        idle_core();
        repeat (2) @(posedge clk);
        #1;
        core_bus.inst_en = 1'b1;
        #1;
        check_reset_outputs("reset");
        idle_core();
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Kseg1 instruction fetch, zero-wait slave.
        mem[32'h1FC0_0000] = 32'h3C1D_8000;
        push(EV_AR, 32'h1FC0_0000, '0, '0, 0);
        push(EV_DONE, 32'h3C1D_8000, 32'h0, '0, 3);
        issue(1'b1, 32'hBFC0_0000, 1'b0, 4'b0000, '0, '0);
        wait_done("t1_done");

        // Halfword store, awready two cycles ahead of wready.
        aw_wait = 0; w_wait = 2;
        push(EV_AW, 32'h0000_1002, '0, 4'b0011, 0);
        push(EV_W, '0, 32'hAABB_CCDD, 4'b0011, 0);
        push(EV_DONE, 32'h3C1D_8000, 32'h0, '0, 5);
        issue(1'b0, '0, 1'b1, 4'b0011, 32'h8000_1002, 32'hAABB_CCDD);
        wait_done("t2_done");
        w_wait = 0;

        // Data load and instruction fetch in one window: data first.
        mem[32'h0000_2000] = 32'h1122_3344;
        mem[32'h1FC0_0010] = 32'h5566_7788;
        push(EV_AR, 32'h0000_2000, '0, '0, 0);
        push(EV_AR, 32'h1FC0_0010, '0, '0, 0);
        push(EV_DONE, 32'h5566_7788, 32'h1122_3344, '0, 5);
        issue(1'b1, 32'h9FC0_0010, 1'b1, 4'b0000, 32'hA000_2000, '0);
        wait_done("t3_done");

        // Slow arready: address must hold for ten cycles, single AR.
        ar_wait = 10;
        mem[32'h0040_0000] = 32'h2408_0001;
        push(EV_AR, 32'h0040_0000, '0, '0, 0);
        push(EV_DONE, 32'h2408_0001, 32'h1122_3344, '0, 13);
        issue(1'b1, 32'h0040_0000, 1'b0, 4'b0000, '0, '0);
        wait_done("t4_done");
        ar_wait = 0;

        // Kseg2 word store (unmapped) with W before AW, then fetch.
        aw_wait = 3;
        mem[32'h1FC0_0020] = 32'h8FA4_0000;
        push(EV_W, '0, 32'hDEAD_BEEF, 4'b1111, 0);
        push(EV_AW, 32'hC000_0010, '0, 4'b1111, 0);
        push(EV_AR, 32'h1FC0_0020, '0, '0, 0);
        push(EV_DONE, 32'h8FA4_0000, 32'h1122_3344, '0, 8);
        issue(1'b1, 32'hBFC0_0020, 1'b1, 4'b1111, 32'hC000_0010, 32'hDEAD_BEEF);
        wait_done("t6_done");
        aw_wait = 0;

        // Byte store with AW and W in the same cycle.
        push(EV_AW, 32'h0000_0100, '0, 4'b1000, 0);
        push(EV_W, '0, 32'h0102_0304, 4'b1000, 0);
        push(EV_DONE, 32'h8FA4_0000, 32'h1122_3344, '0, 3);
        issue(1'b0, '0, 1'b1, 4'b1000, 32'h0000_0100, 32'h0102_0304);
        wait_done("t7_done");

        // Reset while waiting for read data.
        r_wait = 4;
        push(EV_AR, 32'h0000_3000, '0, '0, 0);
        issue(1'b0, '0, 1'b1, 4'b0000, 32'h8000_3000, '0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!axi_bus.rready && n < 50);
        check("t5_reached_r", 32'(axi_bus.rready), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t5_async");
        idle_core();
        repeat (2) @(posedge clk);
        #1;
        reset  = 1'b0;
        r_wait = 0;
        @(posedge clk); #1;

        // Clean restart after the abort.
        mem[32'h0000_3000] = 32'hCAFE_F00D;
        push(EV_AR, 32'h0000_3000, '0, '0, 0);
        push(EV_DONE, 32'h0000_0000, 32'hCAFE_F00D, '0, 3);
        issue(1'b0, '0, 1'b1, 4'b0000, 32'h8000_3000, '0);
        wait_done("t5b_done");

        repeat (5) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
